// File: rtl/despreader_ss_pkg.sv
// Shared types and helpers for the spread-spectrum despreader.
// Group FSM states, default widths and sizing helpers used by every despreader file.
package demapper_ss_pkg;

  localparam int DATA_W_DEF      = 12;
  localparam int SF_LOG2_MAX_DEF = 4;
  localparam int M_W_DEF         = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  function automatic int clamp_sf(input int sf_log2, input int sf_log2_max);
    return (sf_log2 > sf_log2_max) ? sf_log2_max : sf_log2;
  endfunction

  // A sum of 2^SF_LOG2_MAX chips needs SF_LOG2_MAX extra bits to never overflow.
  function automatic int acc_width(input int data_w, input int sf_log2_max);
    return data_w + sf_log2_max;
  endfunction

endpackage

// File: rtl/despreader_ss_if.sv
// Chip-in / symbol-out stream bundle of the despreader.
// The slave modport is the despreader's view; the master modport is the surrounding pipeline's view.
interface despreader_ss_if
  import demapper_ss_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SF_LOG2_MAX = SF_LOG2_MAX_DEF,
  parameter int M_W         = M_W_DEF
);
  localparam int SW = $clog2(SF_LOG2_MAX + 1);

  logic [SW-1:0]            sf_log2_in;
  logic [M_W-1:0]           index_M_in;
  logic                     sof;
  logic                     ival;
  logic                     iready;
  logic signed [DATA_W-1:0] subc_i;
  logic signed [DATA_W-1:0] subc_q;
  logic                     oval;
  logic                     oready;
  logic signed [DATA_W-1:0] osubc_i;
  logic signed [DATA_W-1:0] osubc_q;
  logic [SW-1:0]            index_SS_out;
  logic [M_W-1:0]           index_M_out;
  logic                     group_drop;

  modport slave (
    input  sf_log2_in, index_M_in, sof, ival, subc_i, subc_q, oready,
    output iready, oval, osubc_i, osubc_q, index_SS_out, index_M_out, group_drop
  );

  modport master (
    output sf_log2_in, index_M_in, sof, ival, subc_i, subc_q, oready,
    input  iready, oval, osubc_i, osubc_q, index_SS_out, index_M_out, group_drop
  );
endinterface

// File: rtl/despread_acc.sv
// One channel of the despreader: signed chip accumulator plus divide-by-SF shift.
// DESPREAD_ROUND_EN selects round-half-up with saturation; otherwise a plain floor shift.
module despread_acc
  import demapper_ss_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SF_LOG2_MAX = SF_LOG2_MAX_DEF,
  parameter int SW          = $clog2(SF_LOG2_MAX_DEF + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     add,
  input  logic                     emit,
  input  logic signed [DATA_W-1:0] chip,
  input  logic [SW-1:0]            k,
  output logic signed [DATA_W-1:0] result
);
  localparam int AW = acc_width(DATA_W, SF_LOG2_MAX);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] chip_ext;
  logic signed [AW-1:0] sum;

  // A load starts a fresh group, so the old accumulator contents are ignored.
  assign chip_ext = {{SF_LOG2_MAX{chip[DATA_W-1]}}, chip};
  assign sum      = (load ? AW'(0) : acc) + chip_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (emit) begin
      acc <= '0;
    end else if (load) begin
      acc <= chip_ext;
    end else if (add) begin
      acc <= sum;
    end
  end

`ifdef DESPREAD_ROUND_EN
  localparam logic signed [AW:0] MAX_V = (AW+1)'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [AW:0] MIN_V = (AW+1)'(-(2 ** (DATA_W - 1)));

  logic signed [AW:0] rnd;
  logic signed [AW:0] sum_ext;
  logic signed [AW:0] rounded;

  always_comb begin
    rnd = '0;
    if (k != '0) begin
      rnd = (AW+1)'(1) << (k - SW'(1));
    end
    sum_ext = $signed({sum[AW-1], sum}) + rnd;
    rounded = sum_ext >>> k;
    if (rounded > MAX_V) begin
      result = DATA_W'(MAX_V);
    end else if (rounded < MIN_V) begin
      result = DATA_W'(MIN_V);
    end else begin
      result = DATA_W'(rounded);
    end
  end
`else
  logic signed [AW-1:0] shifted;

  assign shifted = sum >>> k;
  assign result  = DATA_W'(shifted);
`endif

endmodule

// File: rtl/despreader_ss.sv
// Spread-spectrum despreader: averages 2^sf_log2 repeated I/Q chips into one symbol.
// Optional rounding is enabled by defining DESPREAD_ROUND_EN (default build floors).
module despreader_ss
  import demapper_ss_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SF_LOG2_MAX = SF_LOG2_MAX_DEF,
  parameter int M_W         = M_W_DEF
) (
  input logic            clk,
  input logic            rst_n,
  despreader_ss_if.slave bus
);
  localparam int SW = $clog2(SF_LOG2_MAX + 1);
  localparam int CW = SF_LOG2_MAX + 1;

  state_t                   state, state_n;
  logic [CW-1:0]            cnt, cnt_n, last_cnt;
  logic [SW-1:0]            k_lat, k_now, k_use;
  logic [M_W-1:0]           m_lat, m_use;
  logic                     accept, start, load, add, emit, drop;
  logic signed [DATA_W-1:0] res_i, res_q;

  assign bus.iready = !bus.oval || bus.oready;
  assign accept     = bus.ival && bus.iready;
  assign k_now      = SW'(clamp_sf(int'(bus.sf_log2_in), SF_LOG2_MAX));
  assign k_use      = start ? k_now : k_lat;
  assign m_use      = start ? bus.index_M_in : m_lat;
  assign last_cnt   = (CW'(1) << k_lat) - CW'(1);

  // A sof chip always opens a new group, abandoning any partial one.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start   = 1'b0;
    load    = 1'b0;
    add     = 1'b0;
    emit    = 1'b0;
    drop    = 1'b0;
    if (accept) begin
      if (state == IDLE || bus.sof) begin
        start = 1'b1;
        load  = 1'b1;
        drop  = (state == ACCUM);
        if (k_now == '0) begin
          emit    = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          state_n = ACCUM;
          cnt_n   = CW'(1);
        end
      end else begin
        add = 1'b1;
        if (cnt == last_cnt) begin
          emit    = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      k_lat <= '0;
      m_lat <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (start) begin
        k_lat <= k_now;
        m_lat <= bus.index_M_in;
      end
    end
  end

  // A held symbol is only replaced by an emit, which requires the downstream to be taking it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.oval         <= 1'b0;
      bus.osubc_i      <= '0;
      bus.osubc_q      <= '0;
      bus.index_SS_out <= '0;
      bus.index_M_out  <= '0;
      bus.group_drop   <= 1'b0;
    end else begin
      bus.group_drop <= drop;
      if (emit) begin
        bus.oval         <= 1'b1;
        bus.osubc_i      <= res_i;
        bus.osubc_q      <= res_q;
        bus.index_SS_out <= k_use;
        bus.index_M_out  <= m_use;
      end else if (bus.oready) begin
        bus.oval <= 1'b0;
      end
    end
  end

  despread_acc #(.DATA_W(DATA_W), .SF_LOG2_MAX(SF_LOG2_MAX), .SW(SW)) u_acc_i (
    .clk(clk), .rst_n(rst_n), .load(load), .add(add), .emit(emit),
    .chip(bus.subc_i), .k(k_use), .result(res_i)
  );

  despread_acc #(.DATA_W(DATA_W), .SF_LOG2_MAX(SF_LOG2_MAX), .SW(SW)) u_acc_q (
    .clk(clk), .rst_n(rst_n), .load(load), .add(add), .emit(emit),
    .chip(bus.subc_q), .k(k_use), .result(res_q)
  );

endmodule

// File: doc/despreader_ss.md
Name: despreader_ss

Overview:
- Parametrised successor of the receive-side spread-spectrum demapper.
- Accumulates 2^sf_log2 consecutive repeated I/Q chips per symbol and divides the sum by the true spreading factor using a rounded arithmetic shift.
- Sits between the FFT subcarrier output and the QAM demapper.
- Adds over the previous generation: valid/ready backpressure, input gaps within a group, frame resync, and a group-drop indication.

Parameters:
- DATA_W, 12, I/Q sample width (signed two's complement).
- SF_LOG2_MAX, 4, largest supported log2 of the spreading factor (SF_MAX = 16).
- M_W, 3, width of the modulation index passed alongside the data.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sf_log2_in  in  $clog2(SF_LOG2_MAX+1)  log2 of spreading factor; values above SF_LOG2_MAX are clamped to SF_LOG2_MAX
- index_M_in  in  M_W  modulation index
- sof  in  1  frame start; qualified by ival, marks the first chip of a frame
- ival  in  1  input chip valid
- iready  out  1  input ready; equals !oval || oready
- subc_i, subc_q  in  DATA_W  signed chip samples
- oval  out  1  output symbol valid
- oready  in  1  downstream ready
- osubc_i, osubc_q  out  DATA_W  signed despread symbol
- index_SS_out  out  $clog2(SF_LOG2_MAX+1)  sf_log2 latched for the current output symbol
- index_M_out  out  M_W  modulation index latched for the current output symbol
- group_drop  out  1  one-cycle pulse when a partial group is discarded

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: all outputs 0 (iready reads 1 because oval = 0). Counter, accumulators and FSM return to IDLE. Reset mid-group discards the partial sum without pulsing group_drop.
- Accept rule: a chip is accepted when ival && iready.
- FSM states: IDLE, ACCUM.
- IDLE: on an accepted chip, latch sf_log2 (clamped) and index_M_in as the group parameters. If SF = 1, emit the chip directly. Otherwise load the accumulator with the chip, set cnt = 1, and go to ACCUM.
- ACCUM: each accepted chip adds to the accumulator and increments cnt. On the chip where cnt = SF-1, emit the symbol, then go to IDLE.
- Gaps: ival low does not disturb state; accumulation resumes on the next accepted chip.
- Mode changes mid-group: sf_log2_in and index_M_in changes during ACCUM are ignored.
- sof in ACCUM: the partial group is discarded and group_drop pulses for one cycle. The sof chip starts a new group exactly as from IDLE, with parameters latched fresh.
- Accumulator width: DATA_W + SF_LOG2_MAX, signed, per channel; no overflow is possible.
- Emit: sum = acc + chip, then result = (sum + 2^(k-1)) >>> k with k = latched sf_log2. For k = 0, result = sum.
- Rounding: round half toward +inf.
- Result width: always fits DATA_W. The result is still saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1] as a guard.
- Output register:
  - osubc_*, index_SS_out, index_M_out and oval are registered, with latency 1 cycle after the last accepted chip.
  - oval holds until oready.
  - osubc_* and the index outputs hold while oval && !oready.
  - When oval && oready, a new emit in the same cycle reloads the register (oval stays 1); otherwise oval clears.
- Backpressure: iready = !oval || oready (combinational). No chip is lost or duplicated under backpressure.

Optional Feature:
- Macro: DESPREAD_ROUND_EN.
- Defined: rounding offset 2^(k-1) is added before the shift, as above.
- Undefined: plain arithmetic shift (floor toward -inf); no offset adder, no saturation logic.

Decomposition:
- Package demapper_ss_pkg:
  - SF_LOG2_MAX and DATA_W defaults.
  - State enum with IDLE and ACCUM.
  - Function clamp_sf().
  - Function acc_width().
- Sub-module despread_acc:
  - One instance per channel, I and Q.
  - Contains the signed accumulator, shift/round and saturate logic.
  - Driven by load, add and emit strobes plus k from the parent FSM.
- Parent module holds the FSM, counter, parameter latches, output register and handshake.

Test Plan:
- SF=4 (sf_log2=2), I = 10,11,12,13, Q = -10,-11,-12,-13, oready=1 -> one oval pulse. With ROUND_EN: osubc_i=12, osubc_q=-11. Without ROUND_EN: 11 and -12. index_SS_out=2.
- SF=1, 5 back-to-back chips I = 1..5 -> 5 symbols, each equal to its input, each 1 cycle after its chip.
- SF=16, all chips 2047 / -2048 -> osubc_i=2047, osubc_q=-2048, no wrap. sf_log2_in=7 clamps to 4, giving the same result.
- SF=4 with ival gaps of 3 cycles between chips, and sf_log2_in changed to 1 mid-group -> same result as the first test; index_SS_out=2.
- SF=8, sof asserted on the 5th chip -> group_drop pulses once; the next 8 chips form a correct symbol.
- oready held low for 10 cycles while oval=1 -> iready=0, outputs stable. rst_n pulsed low mid-group -> all outputs 0 immediately, and the next group is correct.
